// File: rtl/conv_pkg.sv
// Shared types and helpers for the 2-D convolution sequencer.
package conv_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDrain,
        StWrite,
        StDone
    } conv_state_e;

    localparam logic MODE_VALID = 1'b0;
    localparam logic MODE_PAD   = 1'b1;

    // Worst-case signed sum of K*K products of a zero-extended pixel and a signed coefficient.
    function automatic int acc_width(input int pix_w, input int coef_w, input int k);
        return pix_w + coef_w + 1 + $clog2(k * k);
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate with clear-on-first-tap, followed by a
// round / arithmetic-shift / saturate stage driving the output pixel.
module conv_mac
    import conv_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 4,
    parameter int ACC_W  = acc_width(8, 4, 3)
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [PIX_W-1:0]  pix_i,
    input  logic [COEF_W-1:0] coef_i,
    input  logic [3:0]        shift_i,
    output logic [PIX_W-1:0]  res_o
);

    localparam int PROD_W = PIX_W + COEF_W + 1;
    // Headroom so the rounding constant (up to 2^14) never wraps the sum.
    localparam int RW     = ACC_W + 17;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [RW-1:0]     rnd, sum, shd;

    always_comb begin
        prod  = $signed({{COEF_W{1'b0}}, 1'b0, pix_i})
              * $signed({{(PIX_W + 1){coef_i[COEF_W-1]}}, coef_i});
        acc_d = acc_q;
        if (en_i) begin
            acc_d = clr_i ? ACC_W'(prod) : acc_q + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    always_comb begin
        rnd = '0;
        if (shift_i != 4'd0) begin
            rnd = RW'(1) <<< (shift_i - 4'd1);
        end
        sum = RW'(acc_q) + rnd;
        shd = sum >>> shift_i;
        if (shd[RW-1]) begin
            res_o = '0;
        end else if (|shd[RW-2:PIX_W]) begin
            res_o = '1;
        end else begin
            res_o = shd[PIX_W-1:0];
        end
    end

endmodule

// File: rtl/conv_engine.sv
// 2-D convolution sequencer: walks output pixels in raster order, fetches each K x K window
// one tap per cycle, accumulates in conv_mac and writes the saturated result.
module conv_engine
    import conv_pkg::*;
#(
    parameter int K        = 3,
    parameter int W        = 220,
    parameter int H        = 220,
    parameter int PIX_W    = 8,
    parameter int COEF_W   = 4,
    parameter int ADDR_W   = 16,
    parameter int OUT_BASE = W * H
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    mode,
    input  logic [3:0]              shift,
    input  logic [K*K*COEF_W-1:0]   kernel,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic [PIX_W-1:0]        rd_data,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [PIX_W-1:0]        wr_data
);

    localparam int ACC_W    = acc_width(PIX_W, COEF_W, K);
    localparam int CW       = $clog2((W > H ? W : H) + 1);
    localparam int KW       = $clog2(K + 1);
    localparam bit NO_VALID = (K > W) || (K > H);

    conv_state_e           state_q, state_d;
    logic                  mode_q;
    logic [3:0]            shift_q;
    logic [K*K*COEF_W-1:0] kernel_q;
    logic [CW-1:0]         ox_q, ox_d, oy_q, oy_d;
    logic [KW-1:0]         kx_q, kx_d, ky_q, ky_d;
    logic                  mac_vld_q, mac_clr_q, mac_pad_q;
    logic [COEF_W-1:0]     mac_coef_q, coef_sel;
    logic [PIX_W-1:0]      mac_pix, mac_res;
    logic                  in_range;
    int                    tx, ty, ow, oh, off;

    always_comb begin
        off      = (mode_q == MODE_PAD) ? K / 2 : 0;
        ow       = (mode_q == MODE_PAD) ? W : W - K + 1;
        oh       = (mode_q == MODE_PAD) ? H : H - K + 1;
        tx       = int'(ox_q) + int'(kx_q) - off;
        ty       = int'(oy_q) + int'(ky_q) - off;
        in_range = (tx >= 0) && (tx < W) && (ty >= 0) && (ty < H);
        coef_sel = kernel_q[(int'(ky_q) * K + int'(kx_q)) * COEF_W +: COEF_W];
    end

    always_comb begin
        state_d = state_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        kx_d    = kx_q;
        ky_d    = ky_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ox_d    = '0;
                    oy_d    = '0;
                    kx_d    = '0;
                    ky_d    = '0;
                    state_d = (mode == MODE_VALID && NO_VALID) ? StDone : StFetch;
                end
            end
            StFetch: begin
                if (int'(kx_q) == K - 1) begin
                    kx_d = '0;
                    if (int'(ky_q) == K - 1) begin
                        ky_d    = '0;
                        state_d = StDrain;
                    end else begin
                        ky_d = ky_q + KW'(1);
                    end
                end else begin
                    kx_d = kx_q + KW'(1);
                end
            end
            StDrain: state_d = StWrite;
            StWrite: begin
                state_d = StFetch;
                if (int'(ox_q) == ow - 1) begin
                    ox_d = '0;
                    if (int'(oy_q) == oh - 1) begin
                        oy_d    = '0;
                        state_d = StDone;
                    end else begin
                        oy_d = oy_q + CW'(1);
                    end
                end else begin
                    ox_d = ox_q + CW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= StIdle;
            mode_q     <= MODE_VALID;
            shift_q    <= '0;
            kernel_q   <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            kx_q       <= '0;
            ky_q       <= '0;
            mac_vld_q  <= 1'b0;
            mac_clr_q  <= 1'b0;
            mac_pad_q  <= 1'b0;
            mac_coef_q <= '0;
        end else begin
            state_q <= state_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            kx_q    <= kx_d;
            ky_q    <= ky_d;
            if (state_q == StIdle && start) begin
                mode_q   <= mode;
                shift_q  <= shift;
                kernel_q <= kernel;
            end
            // Tap metadata follows the read by one cycle to line up with rd_data.
            mac_vld_q  <= (state_q == StFetch);
            mac_clr_q  <= (state_q == StFetch) && (kx_q == '0) && (ky_q == '0);
            mac_pad_q  <= !in_range;
            mac_coef_q <= coef_sel;
        end
    end

    always_comb begin
        busy    = (state_q == StFetch) || (state_q == StDrain) || (state_q == StWrite);
        done    = (state_q == StDone);
        rd_en   = (state_q == StFetch) && in_range;
        rd_addr = rd_en ? ADDR_W'(ty * W + tx) : '0;
        wr_en   = (state_q == StWrite);
        wr_addr = wr_en ? ADDR_W'(OUT_BASE + int'(oy_q) * ow + int'(ox_q)) : '0;
        wr_data = wr_en ? mac_res : '0;
        mac_pix = mac_pad_q ? '0 : rd_data;
    end

    conv_mac #(
        .PIX_W  (PIX_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .en_i    (mac_vld_q),
        .clr_i   (mac_clr_q),
        .pix_i   (mac_pix),
        .coef_i  (mac_coef_q),
        .shift_i (shift_q),
        .res_o   (mac_res)
    );

endmodule

// File: tb/tb_conv_engine.sv
// Self-checking bench for conv_engine: table of frames checked against a behavioural
// convolution model, plus mid-frame start, mid-frame reset and zero-output cases.
module tb_conv_engine;

    localparam int K = 3, W = 4, H = 4, PIX_W = 8, COEF_W = 4, ADDR_W = 16;
    localparam int OB = W * H;
    localparam int W2 = 2;
    localparam int RND = -100;

    typedef struct {
        int mode;
        int shift;
        int coef_all;
        int coef_ctr;
        int pix;
        int exp_all;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rstn, start, mode;
    logic [3:0]            shift;
    logic [K*K*COEF_W-1:0] kernel;
    logic                  busy, done, rd_en, wr_en;
    logic [ADDR_W-1:0]     rd_addr, wr_addr;
    logic [PIX_W-1:0]      rd_data, wr_data;

    logic                  start2, mode2;
    logic [3:0]            shift2;
    logic [K*K*COEF_W-1:0] kernel2;
    logic                  busy2, done2, rd_en2, wr_en2;
    logic [ADDR_W-1:0]     rd_addr2, wr_addr2;
    logic [PIX_W-1:0]      rd_data2, wr_data2;

    conv_engine #(
        .K(K), .W(W), .H(H), .PIX_W(PIX_W), .COEF_W(COEF_W), .ADDR_W(ADDR_W), .OUT_BASE(OB)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .mode(mode), .shift(shift), .kernel(kernel),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    conv_engine #(
        .K(K), .W(W2), .H(H), .PIX_W(PIX_W), .COEF_W(COEF_W), .ADDR_W(ADDR_W),
        .OUT_BASE(W2 * H)
    ) dut2 (
        .clk(clk), .rstn(rstn), .start(start2), .mode(mode2), .shift(shift2),
        .kernel(kernel2), .busy(busy2), .done(done2), .rd_en(rd_en2), .rd_addr(rd_addr2),
        .rd_data(rd_data2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2)
    );

    int mem[W*H];
    int coef[K*K];
    int exp_wa[$], exp_wd[$], exp_rd[$];
    int act_wa[$], act_wd[$], act_rd[$];
    int done_tot = 0, both_tot = 0, bad_tot = 0;
    int rd2_tot = 0, wr2_tot = 0, busy2_tot = 0;
    int n_chk = 0, n_fail = 0;
    int wbase, rbase, dbase, bbase, xbase;
    vec_t vt[9];
    int pad_exp[16] = '{4, 6, 6, 4, 6, 9, 9, 6, 6, 9, 9, 6, 4, 6, 6, 4};

    assign rd_data2 = '0;

    // Memory with one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= PIX_W'(mem[int'(rd_addr) % (W * H)]);
    end

    always @(negedge clk) begin
        if (wr_en) begin
            act_wa.push_back(int'(wr_addr));
            act_wd.push_back(int'(wr_data));
        end
        if (rd_en) act_rd.push_back(int'(rd_addr));
        if (rd_en && int'(rd_addr) >= W * H) bad_tot++;
        if (rd_en && wr_en) both_tot++;
        if (done) done_tot++;
        if (rd_en2) rd2_tot++;
        if (wr_en2) wr2_tot++;
        if (busy2) busy2_tot++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [K*K*COEF_W-1:0] pack_kernel();
        logic [K*K*COEF_W-1:0] v;
        v = '0;
        for (int i = 0; i < K * K; i++) v[i*COEF_W +: COEF_W] = COEF_W'(coef[i]);
        return v;
    endfunction

    // Direct convolution over the image array, taps visited in the same raster order.
    function automatic void build_model(input int md, input int sh);
        int ow, oh, off, sum, x, y, v;
        exp_wa.delete();
        exp_wd.delete();
        exp_rd.delete();
        ow  = md ? W : W - K + 1;
        oh  = md ? H : H - K + 1;
        off = md ? K / 2 : 0;
        for (int oy = 0; oy < oh; oy++) begin
            for (int ox = 0; ox < ow; ox++) begin
                sum = 0;
                for (int ky = 0; ky < K; ky++) begin
                    for (int kx = 0; kx < K; kx++) begin
                        x = ox + kx - off;
                        y = oy + ky - off;
                        if (x >= 0 && x < W && y >= 0 && y < H) begin
                            exp_rd.push_back(y * W + x);
                            sum += mem[y*W+x] * coef[ky*K+kx];
                        end
                    end
                end
                v = (sh > 0) ? ((sum + (1 << (sh - 1))) >>> sh) : sum;
                if (v < 0) v = 0;
                if (v > (1 << PIX_W) - 1) v = (1 << PIX_W) - 1;
                exp_wa.push_back(OB + oy * ow + ox);
                exp_wd.push_back(v);
            end
        end
    endfunction

    task automatic run_frame(input int md, input int sh, input bit disturb, input string tag);
        int lat;
        build_model(md, sh);
        wbase = act_wa.size();
        rbase = act_rd.size();
        dbase = done_tot;
        bbase = both_tot;
        xbase = bad_tot;
        @(posedge clk); #1;
        start  = 1'b1;
        mode   = md[0];
        shift  = sh[3:0];
        kernel = pack_kernel();
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, " busy_after_start"}, int'(busy), 1);
        lat = 1;
        while (!done && lat < 1000) begin
            if (disturb && lat == 10) begin
                start  = 1'b1;
                mode   = ~mode;
                shift  = shift + 4'd5;
                kernel = ~kernel;
            end
            if (disturb && lat == 11) start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, exp_wa.size() * (K * K + 2) + 1);
        chk({tag, " busy_at_done"}, int'(busy), 0);
        @(negedge clk); #1;
        @(posedge clk); #1;
        chk({tag, " done_one_cycle"}, int'(done), 0);
        chk({tag, " wr_count"}, act_wa.size() - wbase, exp_wa.size());
        for (int i = 0; i < exp_wa.size() && wbase + i < act_wa.size(); i++) begin
            chk($sformatf("%s wr_addr[%0d]", tag, i), act_wa[wbase+i], exp_wa[i]);
            chk($sformatf("%s wr_data[%0d]", tag, i), act_wd[wbase+i], exp_wd[i]);
        end
        chk({tag, " rd_count"}, act_rd.size() - rbase, exp_rd.size());
        for (int i = 0; i < exp_rd.size() && rbase + i < act_rd.size(); i++) begin
            chk($sformatf("%s rd_addr[%0d]", tag, i), act_rd[rbase+i], exp_rd[i]);
        end
        chk({tag, " done_pulses"}, done_tot - dbase, 1);
        chk({tag, " rd_wr_overlap"}, both_tot - bbase, 0);
        chk({tag, " rd_out_of_range"}, bad_tot - xbase, 0);
    endtask

    task automatic setup(input vec_t v);
        for (int i = 0; i < W * H; i++) begin
            mem[i] = (v.pix < 0) ? int'($urandom_range(255)) : v.pix;
        end
        for (int i = 0; i < K * K; i++) begin
            coef[i] = (v.coef_all == RND) ? int'($urandom_range(15)) - 8 : v.coef_all;
        end
        if (v.coef_ctr != RND) coef[(K * K) / 2] = v.coef_ctr;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wcount, cyc, ox, oy;
        rstn    = 1'b0;
        start   = 1'b0;
        mode    = 1'b0;
        shift   = '0;
        kernel  = '0;
        start2  = 1'b0;
        mode2   = 1'b0;
        shift2  = '0;
        kernel2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset rd_en", int'(rd_en), 0);
        chk("reset wr_en", int'(wr_en), 0);
        chk("reset rd_addr", int'(rd_addr), 0);
        chk("reset wr_addr", int'(wr_addr), 0);
        chk("reset wr_data", int'(wr_data), 0);
        rstn = 1'b1;

        //        mode shift coef_all coef_ctr pix  exp_all
        vt[0] = '{0, 0,  0,   1,   -1,  -1};
        vt[1] = '{0, 3,  1,   RND, 8,   9};
        vt[2] = '{0, 0,  0,   -8,  200, 0};
        vt[3] = '{0, 0,  7,   RND, 255, 255};
        vt[4] = '{1, 0,  1,   RND, 1,   -1};
        vt[5] = '{0, 2,  RND, RND, -1,  -1};
        vt[6] = '{1, 4,  RND, RND, -1,  -1};
        vt[7] = '{1, 0,  RND, RND, -1,  -1};
        vt[8] = '{1, 15, 7,   RND, 255, 0};

        for (int i = 0; i < 9; i++) begin
            setup(vt[i]);
            run_frame(vt[i].mode, vt[i].shift, 1'b0, $sformatf("vec%0d", i));
            if (vt[i].exp_all >= 0) begin
                for (int j = 0; wbase + j < act_wd.size(); j++) begin
                    chk($sformatf("vec%0d const[%0d]", i, j), act_wd[wbase+j], vt[i].exp_all);
                end
            end
            if (i == 0) begin
                for (int j = 0; j < 4 && wbase + j < act_wd.size(); j++) begin
                    ox = j % 2;
                    oy = j / 2;
                    chk($sformatf("identity centre[%0d]", j), act_wd[wbase+j],
                        mem[(oy+1)*W+ox+1]);
                end
            end
            if (i == 4) begin
                for (int j = 0; j < 16 && wbase + j < act_wd.size(); j++) begin
                    chk($sformatf("pad map[%0d]", j), act_wd[wbase+j], pad_exp[j]);
                end
            end
        end

        // Second start and input changes mid-frame must be ignored.
        vt[0] = '{0, 2, RND, RND, -1, -1};
        setup(vt[0]);
        run_frame(0, 2, 1'b1, "restart");
        mode   = 1'b0;
        kernel = pack_kernel();
        wbase  = act_wa.size();
        repeat (20) @(posedge clk);
        #1;
        chk("restart idle_after", act_wa.size() - wbase, 0);
        chk("restart busy_after", int'(busy), 0);

        // Reset during the WRITE of the second output pixel.
        setup(vt[0]);
        wbase = act_wa.size();
        @(posedge clk); #1;
        start  = 1'b1;
        mode   = 1'b0;
        kernel = pack_kernel();
        @(posedge clk); #1;
        start  = 1'b0;
        wcount = 0;
        cyc    = 0;
        while (wcount < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (wr_en) wcount++;
        end
        chk("rst reached_write2", wcount, 2);
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("rst wr_en", int'(wr_en), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst rd_en", int'(rd_en), 0);
        chk("rst done", int'(done), 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        chk("rst writes_before", act_wa.size() - wbase, 2);
        wbase = act_wa.size();
        rbase = act_rd.size();
        dbase = done_tot;
        repeat (30) @(posedge clk);
        #1;
        chk("rst no_writes", act_wa.size() - wbase, 0);
        chk("rst no_reads", act_rd.size() - rbase, 0);
        chk("rst no_done", done_tot - dbase, 0);

        vt[0] = '{1, 1, RND, RND, -1, -1};
        setup(vt[0]);
        run_frame(1, 1, 1'b0, "recover");

        // K wider than the image in valid mode: no outputs, done right away.
        @(posedge clk); #1;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        chk("zero done", int'(done2), 1);
        chk("zero busy", int'(busy2), 0);
        @(posedge clk); #1;
        chk("zero done_drop", int'(done2), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("zero reads", rd2_tot, 0);
        chk("zero writes", wr2_tot, 0);
        chk("zero busy_cycles", busy2_tot, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
